// File: rtl/fnd_pkg.sv
// Shared constants, slot FSM state type and small helpers for the FND scan controller.
package fnd_pkg;

   localparam int DIV_DEF          = 100_000;
   localparam int DEAD_DEF         = 2_000;
   localparam int BLINK_FRAMES_DEF = 128;

   localparam logic [1:0] SEL_ONES  = 2'd0;
   localparam logic [1:0] SEL_TENS  = 2'd1;
   localparam logic [1:0] SEL_HUNDS = 2'd2;
   localparam logic [1:0] SEL_THOUS = 2'd3;

   localparam logic [3:0] COM_OFF = 4'b1111;

   typedef enum logic {ST_DEAD, ST_ON} slot_state_e;

   // Digit k (k>=1) is blank only when it and every higher digit are zero.
   function automatic logic lz_blank(input logic [15:0] d, input logic [1:0] k, input logic en);
      logic b;
      case (k)
         SEL_TENS:  b = en && (d[15:4] == 12'd0);
         SEL_HUNDS: b = en && (d[15:8] == 8'd0);
         SEL_THOUS: b = en && (d[15:12] == 4'd0);
         default:   b = 1'b0;
      endcase
      return b;
   endfunction

   function automatic logic [3:0] com_onehot(input logic [1:0] s);
      return ~(4'b0001 << s);
   endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Digit update handshake between the value logic (master) and the scan controller (slave).
interface fnd_scan_ctrl_if;
   logic [15:0] digits_in;
   logic        upd_req;
   logic        upd_ack;

   modport master (output digits_in, output upd_req, input upd_ack);
   modport slave  (input digits_in, input upd_req, output upd_ack);
endinterface

// File: rtl/fnd_slot_timer.sv
// Slot timer: per-slot counter, digit select, dead-time FSM and end-of-frame tick.
// state   | meaning
// ST_DEAD | cnt < DEAD, all commons held off
// ST_ON   | cnt >= DEAD, selected digit may be lit
module fnd_slot_timer
   import fnd_pkg::*;
#(
   parameter int DIV  = DIV_DEF,
   parameter int DEAD = DEAD_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [1:0] sel,
   output logic [1:0] sel_nxt,
   output logic       on_nxt,
   output logic       frame_tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          wrap;
   slot_state_e   state;
   slot_state_e   state_nxt;

   assign wrap = (cnt == CW'(DIV - 1));

   always_comb begin
      cnt_nxt   = wrap ? '0 : cnt + 1'b1;
      sel_nxt   = wrap ? sel + 2'd1 : sel;
      state_nxt = state;
      case (state)
         ST_DEAD: if (cnt_nxt >= CW'(DEAD)) state_nxt = ST_ON;
         ST_ON:   if (wrap) state_nxt = ST_DEAD;
         default: state_nxt = ST_DEAD;
      endcase
      on_nxt = (state_nxt == ST_ON);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         sel        <= SEL_ONES;
         state      <= ST_DEAD;
         frame_tick <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         sel        <= sel_nxt;
         state      <= state_nxt;
         frame_tick <= (cnt_nxt == CW'(DIV - 1)) && (sel_nxt == SEL_THOUS);
      end
   end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// FND scan controller: tear-free digit shadow, frame-synchronous update handshake,
// leading-zero blanking, blink and decimal point on active-low common strobes.
module fnd_scan_ctrl
   import fnd_pkg::*;
#(
   parameter int DIV          = DIV_DEF,
   parameter int DEAD         = DEAD_DEF,
   parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   fnd_scan_ctrl_if.slave    upd,
   input  logic              lz_en,
   input  logic              blink_en,
   input  logic [3:0]        dp_mask,
   output logic [1:0]        sel,
   output logic [3:0]        digit_1,
   output logic [3:0]        digit_10,
   output logic [3:0]        digit_100,
   output logic [3:0]        digit_1000,
   output logic [3:0]        fnd_com,
   output logic              fnd_dp,
   output logic              frame_tick
);

   generate
      if (DIV < 4 || DEAD < 1 || DEAD >= DIV || BLINK_FRAMES < 1) begin : g_bad_params
         $error("fnd_scan_ctrl: illegal DIV/DEAD/BLINK_FRAMES combination");
      end
   endgenerate

   localparam int FW = $clog2(BLINK_FRAMES) + 1;

   logic [15:0]   shadow;
   logic [15:0]   shadow_nxt;
   logic [FW-1:0] fcnt;
   logic          fcnt_last;
   logic          phase;
   logic          phase_nxt;
   logic [1:0]    sel_nxt;
   logic          on_nxt;
   logic          load;
   logic          lit_nxt;

   fnd_slot_timer #(.DIV(DIV), .DEAD(DEAD)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .sel        (sel),
      .sel_nxt    (sel_nxt),
      .on_nxt     (on_nxt),
      .frame_tick (frame_tick)
   );

   assign digit_1    = shadow[3:0];
   assign digit_10   = shadow[7:4];
   assign digit_100  = shadow[11:8];
   assign digit_1000 = shadow[15:12];

   assign fcnt_last = (fcnt == FW'(BLINK_FRAMES - 1));

   // Strobes are decided from next-cycle timer/shadow/phase so they line up with sel.
   always_comb begin
      load       = frame_tick && upd.upd_req;
      shadow_nxt = load ? upd.digits_in : shadow;
      phase_nxt  = phase;
      if (!blink_en)
         phase_nxt = 1'b1;
      else if (frame_tick && fcnt_last)
         phase_nxt = ~phase;
      lit_nxt = on_nxt && phase_nxt && !lz_blank(shadow_nxt, sel_nxt, lz_en);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow      <= 16'd0;
         upd.upd_ack <= 1'b0;
         fcnt        <= '0;
         phase       <= 1'b1;
         fnd_com     <= COM_OFF;
         fnd_dp      <= 1'b1;
      end else begin
         shadow      <= shadow_nxt;
         upd.upd_ack <= load;
         phase       <= phase_nxt;
         if (!blink_en)
            fcnt <= '0;
         else if (frame_tick)
            fcnt <= fcnt_last ? '0 : fcnt + 1'b1;
         fnd_com <= lit_nxt ? com_onehot(sel_nxt) : COM_OFF;
         fnd_dp  <= lit_nxt ? ~dp_mask[sel_nxt] : 1'b1;
      end
   end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with DIV=8, DEAD=2, BLINK_FRAMES=2 (32-clock frames).
module tb_fnd_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lz_en = 1'b0;
   logic       blink_en = 1'b0;
   logic [3:0] dp_mask = 4'b0000;
   logic [1:0] sel;
   logic [3:0] digit_1, digit_10, digit_100, digit_1000;
   logic [3:0] fnd_com;
   logic       fnd_dp;
   logic       frame_tick;

   int n_vec = 0;
   int n_bad = 0;

   fnd_scan_ctrl_if upd_bus ();

   fnd_scan_ctrl #(.DIV(8), .DEAD(2), .BLINK_FRAMES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .upd        (upd_bus),
      .lz_en      (lz_en),
      .blink_en   (blink_en),
      .dp_mask    (dp_mask),
      .sel        (sel),
      .digit_1    (digit_1),
      .digit_10   (digit_10),
      .digit_100  (digit_100),
      .digit_1000 (digit_1000),
      .fnd_com    (fnd_com),
      .fnd_dp     (fnd_dp),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] digits;
      logic        lz;
      logic [3:0]  dp_mask;
      logic [15:0] exp_com;   // {slot3,slot2,slot1,slot0} value during ON cycles
      logic [3:0]  exp_dp;    // active-low dp per slot during ON cycles
   } vec_t;

   vec_t vecs[7];

   // {ack, frame_tick, sel, com, dp, digits}
   function automatic logic [24:0] snap();
      return {upd_bus.upd_ack, frame_tick, sel, fnd_com, fnd_dp,
              digit_1000, digit_100, digit_10, digit_1};
   endfunction

   task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Checks one whole frame, starting at the negedge of its first cycle.
   task automatic check_frame(input string tag, input logic [15:0] exp_com, input logic [3:0] exp_dp,
                              input logic [15:0] exp_dig, input logic ack0,
                              input int req_i, input logic [15:0] req_dig,
                              input int blank_until, input int blink_off_i);
      for (int i = 0; i < 32; i++) begin
         int s, c;
         logic on;
         logic [3:0] com_e;
         logic dp_e;
         if (i > 0) @(negedge clk);
         s = i / 8;
         c = i % 8;
         on = (c >= 2) && (i >= blank_until);
         com_e = on ? exp_com[s*4 +: 4] : 4'hF;
         dp_e  = on ? exp_dp[s] : 1'b1;
         chk($sformatf("%s i%0d", tag, i), snap(),
             {(i == 0) ? ack0 : 1'b0, (i == 31), 2'(s), com_e, dp_e, exp_dig});
         if (i == 0 && ack0) upd_bus.upd_req = 1'b0;
         if (i == req_i) begin
            upd_bus.digits_in = req_dig;
            upd_bus.upd_req   = 1'b1;
         end
         if (i == blink_off_i) blink_en = 1'b0;
      end
   endtask

   initial begin
      vecs[0] = '{16'h0000, 1'b0, 4'b0000, 16'h7BDE, 4'b1111};
      vecs[1] = '{16'h1234, 1'b0, 4'b0100, 16'h7BDE, 4'b1011};
      vecs[2] = '{16'h0050, 1'b1, 4'b0000, 16'hFFDE, 4'b1111};
      vecs[3] = '{16'h0000, 1'b1, 4'b0001, 16'hFFFE, 4'b1110};
      vecs[4] = '{16'h0050, 1'b0, 4'b0000, 16'h7BDE, 4'b1111};
      vecs[5] = '{16'h0A00, 1'b1, 4'b1111, 16'hFBDE, 4'b1000};
      vecs[6] = '{16'h0001, 1'b1, 4'b1010, 16'hFFFE, 4'b1111};

      upd_bus.digits_in = 16'h0000;
      upd_bus.upd_req   = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset", snap(), {1'b0, 1'b0, 2'd0, 4'hF, 1'b1, 16'h0000});
      rst_n = 1'b1;
      check_frame("rel", 16'h7BDE, 4'hF, 16'h0000, 1'b0, -1, 16'h0, 0, -1);

      // Table: each vector is loaded on the frame_tick cycle just reached.
      for (int v = 0; v < 7; v++) begin
         lz_en             = vecs[v].lz;
         dp_mask           = vecs[v].dp_mask;
         upd_bus.digits_in = vecs[v].digits;
         upd_bus.upd_req   = 1'b1;
         @(negedge clk);
         check_frame($sformatf("vec%0d", v), vecs[v].exp_com, vecs[v].exp_dp,
                     vecs[v].digits, 1'b1, -1, 16'h0, 0, -1);
      end

      // Mid-frame request: no ack and no tearing until the frame boundary.
      lz_en   = 1'b0;
      dp_mask = 4'b0000;
      @(negedge clk);
      check_frame("midreq", 16'h7BDE, 4'hF, 16'h0001, 1'b0, 10, 16'h1234, 0, -1);
      @(negedge clk);
      check_frame("midack", 16'h7BDE, 4'hF, 16'h1234, 1'b1, -1, 16'h0, 0, -1);

      // Blink: two frames visible, two hidden, two visible, then drop blink_en mid-frame.
      @(negedge clk);
      blink_en = 1'b1;
      check_frame("blk0", 16'h7BDE, 4'hF, 16'h1234, 1'b0, -1, 16'h0, 0, -1);
      @(negedge clk);
      check_frame("blk1", 16'h7BDE, 4'hF, 16'h1234, 1'b0, -1, 16'h0, 0, -1);
      @(negedge clk);
      check_frame("blk2", 16'h7BDE, 4'hF, 16'h1234, 1'b0, -1, 16'h0, 32, -1);
      @(negedge clk);
      check_frame("blk3", 16'h7BDE, 4'hF, 16'h1234, 1'b0, -1, 16'h0, 32, -1);
      @(negedge clk);
      check_frame("blk4", 16'h7BDE, 4'hF, 16'h1234, 1'b0, -1, 16'h0, 0, -1);
      @(negedge clk);
      check_frame("blk5", 16'h7BDE, 4'hF, 16'h1234, 1'b0, -1, 16'h0, 0, -1);
      @(negedge clk);
      check_frame("blk6", 16'h7BDE, 4'hF, 16'h1234, 1'b0, -1, 16'h0, 13, 12);

      // Asynchronous reset at sel=2, cnt=5 with a request held across it.
      @(negedge clk);
      repeat (21) @(negedge clk);
      chk("pre_rst", snap(), {1'b0, 1'b0, 2'd2, 4'b1011, 1'b1, 16'h1234});
      upd_bus.digits_in = 16'h5678;
      upd_bus.upd_req   = 1'b1;
      #2 rst_n = 1'b0;
      #1 chk("async_rst", snap(), {1'b0, 1'b0, 2'd0, 4'hF, 1'b1, 16'h0000});
      @(negedge clk);
      rst_n = 1'b1;
      check_frame("rst_rel", 16'h7BDE, 4'hF, 16'h0000, 1'b0, -1, 16'h0, 0, -1);
      @(negedge clk);
      check_frame("rst_ack", 16'h7BDE, 4'hF, 16'h5678, 1'b1, -1, 16'h0, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
